// File: rtl/change_dispenser.sv
// Change-return payout controller: drives the hopper's $10/$5 solenoids one coin at a time,
// waits for the coin-seen sensor after each eject, and keeps the coin inventory.
module change_dispenser #(
   parameter int PULSE_CYC   = 16,
   parameter int TIMEOUT_CYC = 1024,
   parameter int AMT_W       = 4,
   parameter int INV_W       = 6,
   parameter int INIT_TEN    = 10,
   parameter int INIT_FIVE   = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [AMT_W-1:0] amount,
   input  logic             restock,
   input  logic [INV_W-1:0] restock_ten,
   input  logic [INV_W-1:0] restock_five,
   input  logic             coin_seen,
   output logic             eject_ten,
   output logic             eject_five,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic             jam,
   output logic [AMT_W-1:0] remain,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones,
   output logic [INV_W-1:0] inv_ten,
   output logic [INV_W-1:0] inv_five
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_EJECT  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_FAULT  = 3'd5;

   localparam int TW = $clog2(PULSE_CYC + TIMEOUT_CYC) + 1;

   logic [2:0]       state, state_n;
   logic [TW-1:0]    timer, timer_n;
   logic             coin_is_ten, coin_n;
   logic             seen, seen_n;
   logic             coin_prev, rise;
   logic [AMT_W-1:0] remain_n;
   logic [INV_W-1:0] ten_n, five_n;
   logic             short_n, jam_n;
   logic             credit, take_restock;

   function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a, input logic [INV_W-1:0] b);
      logic [INV_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[INV_W] ? {INV_W{1'b1}} : s[INV_W-1:0];
   endfunction

   assign rise = coin_seen & ~coin_prev;

   // remain is in $5 units, so remain*5 in decimal is tens=remain/2, ones=5 when odd
   assign bcd_tens = 4'(remain >> 1);
   assign bcd_ones = remain[0] ? 4'd5 : 4'd0;

   always_comb begin
      state_n      = state;
      timer_n      = timer + TW'(1);
      coin_n       = coin_is_ten;
      seen_n       = seen;
      remain_n     = remain;
      ten_n        = inv_ten;
      five_n       = inv_five;
      short_n      = short;
      jam_n        = jam;
      credit       = 1'b0;
      take_restock = 1'b0;
      case (state)
         S_IDLE: begin
            timer_n      = '0;
            seen_n       = 1'b0;
            take_restock = restock;
            if (req) begin
               remain_n = amount;
               short_n  = 1'b0;
               state_n  = S_SELECT;
            end
         end
         S_SELECT: begin
            timer_n = '0;
            seen_n  = 1'b0;
            if (remain == '0)
               state_n = S_DONE;
            else if (remain >= AMT_W'(2) && inv_ten != '0) begin
               coin_n  = 1'b1;
               state_n = S_EJECT;
            end else if (inv_five != '0) begin
               coin_n  = 1'b0;
               state_n = S_EJECT;
            end else begin
               short_n = 1'b1;
               state_n = S_DONE;
            end
         end
         S_EJECT: begin
            if (rise) seen_n = 1'b1;
            if (timer == TW'(PULSE_CYC - 1)) begin
               timer_n = '0;
               if (seen | rise) credit = 1'b1;
               else             state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (seen | rise)
               credit = 1'b1;
            else if (timer == TW'(TIMEOUT_CYC - 1)) begin
               jam_n   = 1'b1;
               state_n = S_FAULT;
            end
         end
         S_DONE: begin
            timer_n = '0;
            state_n = S_IDLE;
         end
         S_FAULT: begin
            timer_n = '0;
            if (restock) begin
               take_restock = 1'b1;
               jam_n        = 1'b0;
               state_n      = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (credit) begin
         seen_n  = 1'b0;
         state_n = S_SELECT;
         if (coin_is_ten) begin
            remain_n = remain - AMT_W'(2);
            ten_n    = inv_ten - INV_W'(1);
         end else begin
            remain_n = remain - AMT_W'(1);
            five_n   = inv_five - INV_W'(1);
         end
      end
      if (take_restock) begin
         ten_n  = sat_add(inv_ten, restock_ten);
         five_n = sat_add(inv_five, restock_five);
      end
   end

   // Outputs are registered from next-state so the solenoids are glitch-free Moore drives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         timer       <= '0;
         coin_is_ten <= 1'b0;
         seen        <= 1'b0;
         coin_prev   <= 1'b0;
         remain      <= '0;
         inv_ten     <= INV_W'(INIT_TEN);
         inv_five    <= INV_W'(INIT_FIVE);
         short       <= 1'b0;
         jam         <= 1'b0;
         eject_ten   <= 1'b0;
         eject_five  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         coin_is_ten <= coin_n;
         seen        <= seen_n;
         coin_prev   <= coin_seen;
         remain      <= remain_n;
         inv_ten     <= ten_n;
         inv_five    <= five_n;
         short       <= short_n;
         jam         <= jam_n;
         eject_ten   <= (state_n == S_EJECT) &&  coin_n;
         eject_five  <= (state_n == S_EJECT) && !coin_n;
         busy        <= (state_n != S_IDLE);
         done        <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a reference payout model queues the expected coin
// sequence and end-of-payout state; monitors pop and compare as the DUT ejects and finishes.
module tb_change_dispenser;

   localparam int PULSE_CYC   = 16;
   localparam int TIMEOUT_CYC = 1024;
   localparam int AMT_W       = 4;
   localparam int INV_W       = 6;
   localparam int INV_MAX     = (1 << INV_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req = 1'b0;
   logic [AMT_W-1:0] amount = '0;
   logic             restock = 1'b0;
   logic [INV_W-1:0] restock_ten = '0, restock_five = '0;
   logic             coin_seen = 1'b0;
   logic             eject_ten, eject_five, busy, done, short, jam;
   logic [AMT_W-1:0] remain;
   logic [3:0]       bcd_tens, bcd_ones;
   logic [INV_W-1:0] inv_ten, inv_five;

   change_dispenser #(
      .PULSE_CYC(PULSE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .AMT_W(AMT_W), .INV_W(INV_W),
      .INIT_TEN(5), .INIT_FIVE(5)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .amount(amount), .restock(restock),
      .restock_ten(restock_ten), .restock_five(restock_five), .coin_seen(coin_seen),
      .eject_ten(eject_ten), .eject_five(eject_five), .busy(busy), .done(done),
      .short(short), .jam(jam), .remain(remain), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
      .inv_ten(inv_ten), .inv_five(inv_five)
   );

   always #5 clk = ~clk;

   typedef struct { int ten; int rem; } coin_t;
   typedef struct { int rem; int sh; int ten; int five; } done_t;

   coin_t cq[$];
   done_t dq[$];
   int    checks = 0, errors = 0;
   int    m_ten = 5, m_five = 5;
   bit    hopper_en = 1'b1;
   logic  prev_et = 1'b0, prev_ef = 1'b0;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
      end
   endtask

   // Hopper: coin_seen pulse 3 cycles after each eject falls
   always begin
      @(negedge eject_ten or negedge eject_five);
      if (hopper_en && !rst) begin
         repeat (3) @(posedge clk);
         #1 coin_seen = 1'b1;
         @(posedge clk);
         #1 coin_seen = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (eject_ten && eject_five) chk("both_eject", 1, 0);
      if ((eject_ten && !prev_et) || (eject_five && !prev_ef)) begin
         if (cq.size() == 0) chk("unexp_eject", 1, 0);
         else begin
            coin_t c;
            c = cq.pop_front();
            chk("coin_type", int'(eject_ten), c.ten);
            chk("bcd_tens", int'(bcd_tens), (c.rem * 5) / 10);
            chk("bcd_ones", int'(bcd_ones), (c.rem * 5) % 10);
         end
      end
      if (done) begin
         if (dq.size() == 0) chk("unexp_done", 1, 0);
         else begin
            done_t d;
            d = dq.pop_front();
            chk("done_remain", int'(remain), d.rem);
            chk("done_bcd", int'(bcd_tens) * 10 + int'(bcd_ones), d.rem * 5);
            chk("done_short", int'(short), d.sh);
            chk("done_inv_ten", int'(inv_ten), d.ten);
            chk("done_inv_five", int'(inv_five), d.five);
            chk("done_busy", int'(busy), 1);
         end
      end
      prev_et <= eject_ten;
      prev_ef <= eject_five;
   end

   task automatic do_payout(input int amt, output int lat);
      int r;
      bit got;
      r = amt;
      while (1) begin
         if (r >= 2 && m_ten > 0) begin
            cq.push_back('{1, r}); r -= 2; m_ten--;
         end else if (r >= 1 && m_five > 0) begin
            cq.push_back('{0, r}); r -= 1; m_five--;
         end else break;
      end
      dq.push_back('{r, int'(r != 0), m_ten, m_five});
      @(posedge clk); #1 req = 1'b1; amount = AMT_W'(amt);
      @(posedge clk); #1 req = 1'b0;
      lat = 0; got = 1'b0;
      while (lat < 3000 && !got) begin
         @(negedge clk); lat++;
         if (done) got = 1'b1;
      end
      if (!got) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("done_width", int'(done), 0);
      chk("coins_left", cq.size(), 0);
   endtask

   task automatic do_restock(input int t, input int f);
      @(posedge clk); #1 restock = 1'b1; restock_ten = INV_W'(t); restock_five = INV_W'(f);
      @(posedge clk); #1 restock = 1'b0;
      m_ten  = (m_ten + t > INV_MAX) ? INV_MAX : m_ten + t;
      m_five = (m_five + f > INV_MAX) ? INV_MAX : m_five + f;
      @(negedge clk);
      chk("rs_inv_ten", int'(inv_ten), m_ten);
      chk("rs_inv_five", int'(inv_five), m_five);
   endtask

   task automatic wait_sig(input string tag, input bit want_ten, input bit lvl, input int bound);
      int n;
      n = 0;
      while (((want_ten ? eject_ten : eject_five) != lvl) && n < bound) begin
         @(negedge clk); n++;
      end
      if (n >= bound) chk(tag, 0, 1);
   endtask

   initial begin
      int lat, n;
      repeat (2) @(negedge clk);
      chk("rst_eject", int'({eject_ten, eject_five}), 0);
      chk("rst_busy_done", int'({busy, done}), 0);
      chk("rst_short_jam", int'({short, jam}), 0);
      chk("rst_remain", int'(remain), 0);
      chk("rst_bcd", int'({bcd_tens, bcd_ones}), 0);
      chk("rst_inv", int'(inv_ten) * 100 + int'(inv_five), 505);
      @(posedge clk); #1 rst = 1'b0;

      // 7 from 5/5: T,T,T,F -> 2/4
      do_payout(7, lat);
      chk("t1_inv", int'(inv_ten) * 100 + int'(inv_five), 204);
      // drain tens, then restock fives to 0/10
      do_payout(4, lat);
      do_restock(0, 6);
      do_payout(4, lat);
      chk("t2_inv_five", int'(inv_five), 6);
      // reach 1/1, then short payout
      do_payout(5, lat);
      do_restock(1, 0);
      do_payout(5, lat);
      chk("t3_short", int'(short), 1);
      chk("t3_remain", int'(remain), 2);

      // jam: hopper silent
      do_restock(1, 1);
      hopper_en = 1'b0;
      cq.push_back('{1, 3});
      @(posedge clk); #1 req = 1'b1; amount = AMT_W'(3);
      @(posedge clk); #1 req = 1'b0;
      wait_sig("jam_eject_hi", 1'b1, 1'b1, 10);
      wait_sig("jam_eject_lo", 1'b1, 1'b0, PULSE_CYC + 10);
      n = 0;
      while (!jam && n < TIMEOUT_CYC + 50) begin
         @(negedge clk); n++;
      end
      chk("jam_latency", n, TIMEOUT_CYC);
      chk("jam_eject", int'({eject_ten, eject_five}), 0);
      chk("jam_busy", int'(busy), 1);
      chk("jam_remain", int'(remain), 3);
      @(posedge clk); #1 req = 1'b1; amount = AMT_W'(1);
      @(posedge clk); #1 req = 1'b0;
      repeat (3) @(negedge clk);
      chk("jam_req_ign", int'(remain) * 10 + int'(jam), 31);
      do_restock(2, 2);
      chk("jam_clear", int'({jam, busy}), 0);
      hopper_en = 1'b1;

      // zero amount, done two cycles after req
      do_payout(0, lat);
      chk("zero_lat", lat, 2);
      do_restock(0, 57);
      do_restock(0, 10);
      chk("sat_five", int'(inv_five), 63);

      // reset mid-EJECT
      hopper_en = 1'b0;
      cq.push_back('{1, 3});
      @(posedge clk); #1 req = 1'b1; amount = AMT_W'(3);
      @(posedge clk); #1 req = 1'b0;
      wait_sig("rst_eject_hi", 1'b1, 1'b1, 10);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_eject", int'(eject_ten), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_inv", int'(inv_ten) * 100 + int'(inv_five), 505);
      @(posedge clk); #1 rst = 1'b0;
      m_ten = 5; m_five = 5;
      hopper_en = 1'b1;
      repeat (2) @(posedge clk);
      do_payout(3, lat);
      chk("post_rst_inv", int'(inv_ten) * 100 + int'(inv_five), 404);
      chk("dq_left", dq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=1 want=0");
      $fatal(1, "timeout");
   end

endmodule
